// File: rtl/down_cnt_pkg.sv
// Shared width default and constants for the cascadable down counter.
package down_cnt_pkg;

   localparam int unsigned CNT_WIDTH = 8;

   localparam logic [CNT_WIDTH-1:0] ZERO     = '0;
   localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

endpackage : down_cnt_pkg

// File: rtl/btn_pulser.sv
// Synchronises a raw button level and emits a single-cycle pulse on its rising edge.
module btn_pulser (
   input  logic clk,
   input  logic rst,
   input  logic btnIn,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s3;

   // Two-flop synchroniser followed by a history flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btnIn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // High for the one cycle where the synchronised level has risen but history has not.
   assign pulse = s2 & ~s3;

endmodule : btn_pulser

// File: rtl/down_counter8.sv
// Loadable down counter driven by debounced-style button pulses, with borrow-out for cascading.
module down_counter8
   import down_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] parIn,
   input  logic             bi,
   input  logic             ld,
   input  logic             cen,
   output logic [WIDTH-1:0] parOut,
   output logic             bo
);

   logic bi_p;
   logic ld_p;
   logic dec;

   btn_pulser u_bi_pulser (
      .clk   (clk),
      .rst   (rst),
      .btnIn (bi),
      .pulse (bi_p)
   );

   btn_pulser u_ld_pulser (
      .clk   (clk),
      .rst   (rst),
      .btnIn (ld),
      .pulse (ld_p)
   );

   // A load pulse always overrides a coincident borrow-in.
   assign dec = bi_p & cen & ~ld_p;

   // Count register: reset, then load, then decrement, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         parOut <= WIDTH'(ZERO);
      end else if (ld_p) begin
         parOut <= parIn;
      end else if (dec) begin
         parOut <= parOut - WIDTH'(1);
      end
   end

   // Borrow-out flags the cycle that precedes the zero to all-ones wrap; silent during reset.
   assign bo = ~rst & dec & (parOut == WIDTH'(ZERO));

endmodule : down_counter8

// File: tb/tb_down_counter8.sv
// Self-checking bench for down_counter8 using a per-cycle expected-value scoreboard.
module tb_down_counter8;
   import down_cnt_pkg::*;

   typedef struct packed {
      logic [CNT_WIDTH-1:0] cnt;
      logic                 bo;
   } exp_t;

   logic                 clk;
   logic                 rst;
   logic [CNT_WIDTH-1:0] par_in;
   logic                 bi;
   logic                 ld;
   logic                 cen;
   logic [CNT_WIDTH-1:0] par_out;
   logic                 bo;

   exp_t sb_q[$];
   int   vectors;
   int   miscompares;

   down_counter8 #(.WIDTH(CNT_WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .parIn  (par_in),
      .bi     (bi),
      .ld     (ld),
      .cen    (cen),
      .parOut (par_out),
      .bo     (bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: wait for the rising edge, drive inputs just after it, return at the falling edge.
   task automatic cycle(input logic r, input logic l, input logic b, input logic c,
                        input logic [CNT_WIDTH-1:0] p);
      @(posedge clk);
      #1;
      rst    = r;
      ld     = l;
      bi     = b;
      cen    = c;
      par_in = p;
      @(negedge clk);
   endtask

   // Loads a value with a one-cycle ld press and lets the synchroniser drain.
   task automatic do_load(input logic [CNT_WIDTH-1:0] v);
      for (int c = 0; c < 6; c++) cycle(1'b0, c == 0, 1'b0, 1'b0, v);
   endtask

   task automatic test_reset();
      exp_t e;
      for (int c = 0; c < 3; c++) begin
         cycle(c < 2, 1'b0, 1'b0, 1'b0, 8'h3C);
         sb_q.push_back('{cnt: ZERO, bo: 1'b0});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL reset c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   task automatic test_load();
      exp_t e;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b0, c < 4, 1'b0, 1'b0, (c < 4) ? 8'h05 : 8'h99);
         sb_q.push_back('{cnt: (c >= 3) ? 8'h05 : ZERO, bo: 1'b0});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL load c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   task automatic test_countdown();
      exp_t                 e;
      logic [CNT_WIDTH-1:0] exp_cnt;
      int                   phase;
      do_load(8'h03);
      exp_cnt = 8'h03;
      for (int c = 0; c < 20; c++) begin
         phase = c % 5;
         cycle(1'b0, 1'b0, phase < 2, 1'b1, 8'h00);
         if (phase == 3) exp_cnt = exp_cnt - 8'h01;
         sb_q.push_back('{cnt: exp_cnt, bo: (phase == 2) && (exp_cnt == ZERO)});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL countdown c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
      vectors++;
      if (par_out !== ALL_ONES) begin
         miscompares++;
         $display("FAIL countdown_wrap: parOut=%h, expected %h", par_out, ALL_ONES);
      end
   endtask

   task automatic test_enable_gating();
      exp_t e;
      do_load(8'h10);
      for (int c = 0; c < 15; c++) begin
         cycle(1'b0, 1'b0, (c % 5) < 2, 1'b0, 8'h00);
         sb_q.push_back('{cnt: 8'h10, bo: 1'b0});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL enable_gating c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      do_load(ZERO);
      for (int c = 0; c < 7; c++) begin
         cycle(1'b0, c < 2, c < 2, 1'b1, 8'hA5);
         sb_q.push_back('{cnt: (c >= 3) ? 8'hA5 : ZERO, bo: 1'b0});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL simultaneous c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   task automatic test_long_press();
      exp_t e;
      do_load(8'h20);
      for (int c = 0; c < 55; c++) begin
         cycle(1'b0, 1'b0, c < 50, 1'b1, 8'h00);
         sb_q.push_back('{cnt: (c >= 3) ? 8'h1F : 8'h20, bo: 1'b0});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL long_press c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t                 e;
      logic [CNT_WIDTH-1:0] exp_cnt;
      do_load(8'h42);
      for (int c = 0; c < 17; c++) begin
         // ld pressed at c=0 pulses during c=2; reset lands on that same cycle, bi held across it.
         cycle(c == 2, c == 0, (c >= 2) && (c <= 12), 1'b1, 8'h77);
         if (c <= 2)      exp_cnt = 8'h42;
         else if (c <= 5) exp_cnt = ZERO;
         else             exp_cnt = ALL_ONES;
         sb_q.push_back('{cnt: exp_cnt, bo: c == 5});
         e = sb_q.pop_front();
         vectors++;
         if (par_out !== e.cnt || bo !== e.bo) begin
            miscompares++;
            $display("FAIL reset_mid c=%0d: parOut=%h bo=%b, expected parOut=%h bo=%b",
                     c, par_out, bo, e.cnt, e.bo);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      ld          = 1'b0;
      bi          = 1'b0;
      cen         = 1'b0;
      par_in      = '0;
      test_reset();
      test_load();
      test_countdown();
      test_enable_gating();
      test_simultaneous();
      test_long_press();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_down_counter8

// File: doc/down_counter8.md
DOWN_COUNTER8 -- requirements
Module: down_counter8

Interface
REQ-001 Parameter: WIDTH, 8, counter and parallel-bus width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: parIn  input  WIDTH  parallel load value.
REQ-005 Port: bi  input  1  borrow-in button level, asynchronous to clk, raw (unsynchronised).
REQ-006 Port: ld  input  1  load button level, asynchronous to clk, raw (unsynchronised).
REQ-007 Port: cen  input  1  count enable level, synchronous to clk.
REQ-008 Port: parOut  output  WIDTH  current count, registered.
REQ-009 Port: bo  output  1  borrow-out, combinational, for cascading a more-significant stage.

Function
REQ-010 bi and ld SHALL each pass through one btn_pulser instance, yielding internal single-cycle pulses bi_p and ld_p.
REQ-011 btn_pulser SHALL use a 2-flop synchroniser (s1, s2) plus a history flop s3, with pulse = s2 & ~s3.
REQ-012 A button held high from before edge k SHALL give pulse high for exactly the cycle between edges k+1 and k+2.
REQ-013 The pulse SHALL not reassert until the button has been sampled low and then high again.
REQ-014 Counter update priority per edge: rst, then ld_p, then decrement, then hold.
REQ-015 When ld_p=1 (and rst=0), parOut SHALL load parIn at that edge, regardless of cen and bi_p.
REQ-016 When ld_p=0 and bi_p=1 and cen=1, parOut SHALL become parOut-1 modulo 2^WIDTH at that edge.
REQ-017 In all other cases parOut SHALL hold its value.
REQ-018 Wrap-around: parOut=0 with a decrement SHALL yield all-ones (8'hFF for WIDTH=8).
REQ-019 bo SHALL equal bi_p & cen & ~ld_p & (parOut==0).
REQ-020 bo SHALL therefore be high only in the cycle preceding the 0-to-all-ones wrap.
REQ-021 Simultaneous ld_p and bi_p: the load SHALL win, the decrement SHALL be discarded, and bo SHALL be 0.
REQ-022 Total latency from button rising to parOut change SHALL be 3 clk edges (2 synchroniser edges plus 1 update edge).

Reset
REQ-023 While rst=1 at an edge, parOut SHALL become 0 and all btn_pulser flops SHALL become 0.
REQ-024 bo SHALL read 0 during reset and in the cycle after it, unless REQ-025 applies.
REQ-025 A button still held through reset release SHALL produce exactly one pulse after release, timed per REQ-012 relative to the first edge with rst=0.
REQ-026 rst asserted mid-pulse SHALL cancel that pulse; no load or decrement SHALL occur on the reset edge.

Structure
REQ-027 Package down_cnt_pkg SHALL hold the WIDTH default (8) and the ZERO and ALL_ONES constants; the top and the bench SHALL import it.
REQ-028 Sub-module btn_pulser (ports clk, rst, btnIn, pulse) SHALL be the only sub-module and SHALL be instantiated twice.
REQ-029 No latches are permitted.
REQ-030 bo SHALL be the only combinational output.

Verification
REQ-031 Reset then load: rst for 2 cycles, parIn=8'h05, ld held 4 cycles -> parOut=8'h05 exactly 3 edges after ld rises, loaded once only.
REQ-032 Countdown: from 8'h03 with cen=1, 4 separate bi presses -> parOut steps 02, 01, 00, FF; bo=1 only during the press that takes 00 to FF.
REQ-033 Enable gating: parOut=8'h10, cen=0, 3 bi presses -> parOut stays 8'h10 and bo stays 0.
REQ-034 Simultaneous events: parOut=8'h00, parIn=8'hA5, ld and bi rise on the same edge -> parOut=8'hA5, bo=0 throughout.
REQ-035 Long press: bi held 50 cycles with cen=1 from 8'h20 -> parOut=8'h1F, a single decrement.
REQ-036 Reset mid-operation: rst asserted in the ld_p cycle with parIn=8'h77 -> parOut=8'h00; bi held through reset release -> exactly one decrement to 8'hFF.
